// File: rtl/seq101_pkg.sv
// seq101_pkg: shared "101" detector state encoding
package seq101_pkg;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10} state_t;
endpackage

// File: rtl/seq101_step.sv
// seq101_step: one step of the overlapping Mealy "101" detector (state_i, bit_i -> next_state_o, hit_o)
module seq101_step
  import seq101_pkg::*;
(
  input  state_t state_i,
  input  logic   bit_i,
  output state_t next_state_o,
  output logic   hit_o
);
  always_comb begin
    next_state_o = bit_i ? S1 : (state_i == S1 ? S2 : S0);
    hit_o        = bit_i && state_i == S2;
  end
endmodule

// File: rtl/seq101_sched.sv
// seq101_sched: round-robin scheduler feeding NCH serial channels through one shared "101" detector
module seq101_sched
  import seq101_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         seq_in,
  input  logic [NCH-1:0]         ctx_clr,
  output logic [NCH-1:0]         gnt,
  output logic                   det_hit,
  output logic [$clog2(NCH)-1:0] det_ch,
  output logic                   det_vld,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [1:0]             crnt_state
);
  localparam int CW = $clog2(NCH);
  state_t           ctx_q [NCH];
  state_t           cur, nxt, st_q;
  logic [CW-1:0]    ptr_q, ptr_d, gidx, det_ch_q;
  logic [NCH-1:0]   elig;
  logic             any, hit, det_vld_q, det_hit_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // gating by reset keeps gnt low for the whole time reset is held
  assign elig = (en && reset) ? req & ~ctx_clr : '0;
  // scan from the farthest offset down so the closest eligible channel to ptr wins
  always_comb begin
    gidx = '0;
    any  = 1'b0;
    for (int o = NCH - 1; o >= 0; o--) begin
      int j;
      j = (int'(ptr_q) + o) % NCH;
      if (elig[j]) begin
        gidx = CW'(j);
        any  = 1'b1;
      end
    end
  end
  assign gnt = any ? {{(NCH-1){1'b0}}, 1'b1} << gidx : '0;
  assign cur = ctx_q[gidx];
  seq101_step u_step (
    .state_i      (cur),
    .bit_i        (seq_in[gidx]),
    .next_state_o (nxt),
    .hit_o        (hit)
  );
  always_comb begin
    ptr_d = any ? (gidx == CW'(NCH - 1) ? '0 : gidx + 1'b1) : ptr_q;
    cnt_d = (any && hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) ctx_q[i] <= S0;
      ptr_q     <= '0;
      det_vld_q <= 1'b0;
      det_hit_q <= 1'b0;
      det_ch_q  <= '0;
      st_q      <= S0;
      cnt_q     <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ctx_clr[i]) ctx_q[i] <= S0;
        else if (any && gidx == CW'(i)) ctx_q[i] <= nxt;
      end
      ptr_q     <= ptr_d;
      det_vld_q <= any;
      det_hit_q <= any && hit;
      if (any) begin
        det_ch_q <= gidx;
        st_q     <= nxt;
      end
      cnt_q <= cnt_d;
    end
  end
  assign det_vld    = det_vld_q;
  assign det_hit    = det_hit_q;
  assign det_ch     = det_ch_q;
  assign crnt_state = st_q;
  assign hit_cnt    = cnt_q;
endmodule
